armleocpu_axi_bram: RTL

ARMLEOCPU_AXI_BRAM -- requirements
Module: armleocpu_axi_bram

---
 rtl/armleocpu_axi_bram_pkg.sv | 21 ++
 rtl/armleocpu_mem_1rw.sv | 34 +++
 rtl/armleocpu_axi_bram.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/armleocpu_axi_bram_pkg.sv
// Shared AXI constants and controller state type for the BRAM subordinate.
package armleocpu_axi_bram_pkg;

  localparam logic [1:0] AXI_BURST_FIXED    = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP     = 2'b10;
  localparam logic [1:0] AXI_BURST_RESERVED = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_READ,
    STATE_WRITE,
    STATE_WRITE_RESP
  } state_t;

endpackage

// File: rtl/armleocpu_mem_1rw.sv
// Single-port memory: synchronous read with one-cycle latency, byte write enables.
// Read data holds its value while i_read is low, which lets the AXI side stall.
module armleocpu_mem_1rw #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int STROBES   = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      i_address,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] o_readdata,
  input  logic                  i_write,
  input  logic [STROBES-1:0]    i_byteenable,
  input  logic [DATA_WIDTH-1:0] i_writedata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Byte-masked write and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (i_write) begin
      for (int i = 0; i < STROBES; i++) begin
        if (i_byteenable[i]) begin
          r_mem[i_address][i*8 +: 8] <= i_writedata[i*8 +: 8];
        end
      end
    end
    if (i_read) begin
      o_readdata <= r_mem[i_address];
    end
  end

endmodule

// File: rtl/armleocpu_axi_bram.sv
// AXI4 subordinate backed by a single-port BRAM. One transaction at a time;
// reads win over writes when both address channels are valid together.
module armleocpu_axi_bram
  import armleocpu_axi_bram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  localparam int DATA_STROBES = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [ID_WIDTH-1:0]     axi_awid,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,

  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_STROBES-1:0] axi_wstrb,
  input  logic                    axi_wlast,

  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  output logic [1:0]              axi_bresp,
  output logic [ID_WIDTH-1:0]     axi_bid,

  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  input  logic [ID_WIDTH-1:0]     axi_arid,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,

  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [ID_WIDTH-1:0]     axi_rid
);

  localparam int STROBE_BITS = $clog2(DATA_STROBES);
  localparam int IDX_W       = $clog2(DEPTH);
  // One extra bit so the byte capacity itself is representable
  localparam logic [ADDR_WIDTH:0] BYTE_CAPACITY = (ADDR_WIDTH+1)'(DEPTH * DATA_STROBES);

  // Next beat address for both read and write bursts; reserved burst acts as INCR
  function automatic logic [ADDR_WIDTH-1:0] burst_next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] result;
    step      = ADDR_WIDTH'(1) << size;
    incr      = addr + step;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      AXI_BURST_FIXED: result = addr;
      AXI_BURST_WRAP:  result = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:         result = incr;
    endcase
    return result;
  endfunction

  state_t                 r_state;
  state_t                 w_state_next;

  logic [ID_WIDTH-1:0]    r_id;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [7:0]             r_len;
  logic [2:0]             r_size;
  logic [1:0]             r_burst;
  logic [7:0]             r_count;

  logic                   r_rvalid;
  logic                   r_rlast;
  logic [1:0]             r_rresp;
  logic                   r_rd_oor;
  logic [1:0]             r_bresp;

  logic                   w_arready;
  logic                   w_awready;
  logic                   w_wready;
  logic                   w_bvalid;
  logic                   w_rd_issue;
  logic                   w_wr_beat;
  logic                   w_oor;
  logic [ADDR_WIDTH-1:0]  w_addr_next;
  logic [DATA_WIDTH-1:0]  w_mem_rdata;

  assign w_oor       = ({1'b0, r_addr} >= BYTE_CAPACITY);
  assign w_addr_next = burst_next_addr(r_addr, r_len, r_size, r_burst);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= STATE_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode; everything is gated while rst_n is low
  // so an abandoned burst cannot touch memory on the reset edge
  always_comb begin
    w_state_next = r_state;
    w_arready    = 1'b0;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    w_rd_issue   = 1'b0;
    w_wr_beat    = 1'b0;
    case (r_state)
      STATE_IDLE: begin
        w_arready = rst_n && axi_arvalid;
        w_awready = rst_n && axi_awvalid && !axi_arvalid;
        if (axi_arvalid) begin
          w_state_next = STATE_READ;
        end else if (axi_awvalid) begin
          w_state_next = STATE_WRITE;
        end
      end
      STATE_READ: begin
        // Read the next beat when the output slot is empty or being drained
        w_rd_issue = rst_n && (!r_rvalid || (axi_rready && !r_rlast));
        if (r_rvalid && axi_rready && r_rlast) begin
          w_state_next = STATE_IDLE;
        end
      end
      STATE_WRITE: begin
        w_wready  = rst_n;
        w_wr_beat = rst_n && axi_wvalid;
        if (w_wr_beat && (axi_wlast || (r_count == 8'd0))) begin
          w_state_next = STATE_WRITE_RESP;
        end
      end
      STATE_WRITE_RESP: begin
        w_bvalid = 1'b1;
        if (axi_bready) begin
          w_state_next = STATE_IDLE;
        end
      end
      default: w_state_next = STATE_IDLE;
    endcase
  end

  // Transaction context, beat counter and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_count  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= AXI_RESP_OKAY;
      r_rd_oor <= 1'b0;
      r_bresp  <= AXI_RESP_OKAY;
    end else begin
      if (w_arready) begin
        r_id    <= axi_arid;
        r_addr  <= axi_araddr;
        r_len   <= axi_arlen;
        r_size  <= axi_arsize;
        r_burst <= axi_arburst;
        r_count <= axi_arlen;
      end else if (w_awready) begin
        r_id    <= axi_awid;
        r_addr  <= axi_awaddr;
        r_len   <= axi_awlen;
        r_size  <= axi_awsize;
        r_burst <= axi_awburst;
        r_count <= axi_awlen;
        r_bresp <= AXI_RESP_OKAY;
      end

      if (w_rd_issue) begin
        r_rvalid <= 1'b1;
        r_rlast  <= (r_count == 8'd0);
        r_rresp  <= w_oor ? AXI_RESP_DECERR : AXI_RESP_OKAY;
        r_rd_oor <= w_oor;
        r_addr   <= w_addr_next;
        if (r_count != 8'd0) begin
          r_count <= r_count - 8'd1;
        end
      end else if (r_rvalid && axi_rready) begin
        r_rvalid <= 1'b0;
      end

      if (w_wr_beat) begin
        if (w_oor) begin
          r_bresp <= AXI_RESP_DECERR;
        end
        r_addr <= w_addr_next;
        if (r_count != 8'd0) begin
          r_count <= r_count - 8'd1;
        end
      end
    end
  end

  armleocpu_mem_1rw #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk          (clk),
    .i_address    (r_addr[STROBE_BITS +: IDX_W]),
    .i_read       (w_rd_issue),
    .o_readdata   (w_mem_rdata),
    .i_write      (w_wr_beat && !w_oor),
    .i_byteenable (axi_wstrb),
    .i_writedata  (axi_wdata)
  );

  assign axi_arready = w_arready;
  assign axi_awready = w_awready;
  assign axi_wready  = w_wready;
  assign axi_bvalid  = w_bvalid;
  assign axi_bresp   = r_bresp;
  assign axi_bid     = r_id;
  assign axi_rvalid  = r_rvalid;
  assign axi_rresp   = r_rresp;
  assign axi_rlast   = r_rlast;
  assign axi_rid     = r_id;
  assign axi_rdata   = r_rd_oor ? '0 : w_mem_rdata;

endmodule
